// File: rtl/csi_pkg.sv
// Shared types and constants for the CSI lane de-skew path.
package csi_pkg;

    localparam int BYTE_W       = 8;
    localparam int NUM_LANE_DEF = 2;
    localparam int DEPTH_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ALL,
        ALIGNED,
        ERROR
    } state_e;

endpackage

// File: rtl/csi_lane_aligner_if.sv
// Byte-lane bundle between the per-lane receivers and the word assembler.
interface csi_lane_aligner_if #(
    parameter int NUM_LANE = csi_pkg::NUM_LANE_DEF
);
    import csi_pkg::*;

    logic                         in_line;
    logic [BYTE_W*NUM_LANE-1:0]   lane_dat;
    logic [NUM_LANE-1:0]          lane_vld;
    logic [BYTE_W*NUM_LANE-1:0]   out_dat;
    logic                         out_vld;
    logic                         err_skew;
    logic                         aligned;

    modport master (
        output in_line, lane_dat, lane_vld,
        input  out_dat, out_vld, err_skew, aligned
    );

    modport slave (
        input  in_line, lane_dat, lane_vld,
        output out_dat, out_vld, err_skew, aligned
    );

endinterface

// File: rtl/csi_lane_fifo.sv
// Single-lane first-word-fall-through byte FIFO with synchronous flush.
module csi_lane_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             wr_en, rd_en;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    // A full FIFO still accepts a byte when the same edge pops one.
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end

endmodule

// File: rtl/csi_lane_aligner.sv
// NUM_LANE-generic byte de-skew: buffers each lane until all lanes have started, then emits aligned words.
module csi_lane_aligner
    import csi_pkg::*;
#(
    parameter int NUM_LANE = NUM_LANE_DEF,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               areset_n,
    csi_lane_aligner_if.slave  bus
);
    localparam int CW = $clog2(DEPTH);
    localparam int DW = BYTE_W * NUM_LANE;

    state_e              state_q, state_d;
    logic [NUM_LANE-1:0] seen_q, seen_d;
    logic [CW-1:0]       skew_q, skew_d;
    logic [DW-1:0]       out_dat_q, out_dat_d;
    logic                out_vld_q, out_vld_d;
    logic                err_q, err_d;
    logic                aligned_q, aligned_d;

    logic [DW-1:0]       fifo_dout;
    logic [NUM_LANE-1:0] fifo_full, fifo_empty;
    logic                all_seen, pop, flush, ovf;

    assign all_seen = &(seen_q | bus.lane_vld);
    assign flush    = !bus.in_line || (state_q == ERROR);
    assign pop      = bus.in_line && (state_q == ALIGNED) && !(|fifo_empty);
    assign ovf      = |(bus.lane_vld & fifo_full);

    for (genvar k = 0; k < NUM_LANE; k++) begin : g_lane
        csi_lane_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (BYTE_W)
        ) u_fifo (
            .clk      (clk),
            .areset_n (areset_n),
            .push_i   (bus.lane_vld[k] && (state_q != ERROR)),
            .pop_i    (pop),
            .flush_i  (flush),
            .din_i    (bus.lane_dat[k*BYTE_W +: BYTE_W]),
            .dout_o   (fifo_dout[k*BYTE_W +: BYTE_W]),
            .full_o   (fifo_full[k]),
            .empty_o  (fifo_empty[k])
        );
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        seen_d    = seen_q;
        skew_d    = skew_q;
        out_dat_d = out_dat_q;
        out_vld_d = 1'b0;
        err_d     = 1'b0;
        if (!bus.in_line) begin
            // End of packet outranks every other transition; leftovers are dropped.
            state_d = IDLE;
            seen_d  = '0;
            skew_d  = '0;
        end else begin
            seen_d = seen_q | bus.lane_vld;
            case (state_q)
                IDLE: begin
                    if (|bus.lane_vld) begin
                        skew_d  = '0;
                        state_d = all_seen ? ALIGNED : WAIT_ALL;
                    end
                end
                WAIT_ALL: begin
                    skew_d = skew_q + 1'b1;
                    if (all_seen) begin
                        state_d = ALIGNED;
                    end else if (skew_d == CW'(DEPTH - 1)) begin
                        // One more cycle without the late lane would exceed the FIFO depth.
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
                ALIGNED: begin
                    if (pop) begin
                        out_dat_d = fifo_dout;
                        out_vld_d = 1'b1;
                    end else if (ovf) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end
                ERROR:   ;
                default: state_d = IDLE;
            endcase
        end
        aligned_d = (state_d == ALIGNED);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= IDLE;
            seen_q    <= '0;
            skew_q    <= '0;
            out_dat_q <= '0;
            out_vld_q <= 1'b0;
            err_q     <= 1'b0;
            aligned_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seen_q    <= seen_d;
            skew_q    <= skew_d;
            out_dat_q <= out_dat_d;
            out_vld_q <= out_vld_d;
            err_q     <= err_d;
            aligned_q <= aligned_d;
        end
    end

    assign bus.out_dat  = out_dat_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.err_skew = err_q;
    assign bus.aligned  = aligned_q;

endmodule

// File: tb/tb_csi_lane_aligner.sv
// Scoreboard bench for csi_lane_aligner: a 2-lane and a 4-lane instance, both DEPTH=4.
module tb_csi_lane_aligner;
    import csi_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        int          edge_n;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic areset_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    exp_t q2[$];
    exp_t q4[$];
    int   eq2[$];
    int   eq4[$];

    logic       line_r;
    logic [7:0] dat_r [4];
    logic [3:0] vld_r;
    int         sel_r;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    csi_lane_aligner_if #(.NUM_LANE(2)) if2 ();
    csi_lane_aligner_if #(.NUM_LANE(4)) if4 ();

    assign if2.in_line  = (sel_r == 0) && line_r;
    assign if2.lane_dat = {dat_r[1], dat_r[0]};
    assign if2.lane_vld = (sel_r == 0) ? vld_r[1:0] : 2'b00;
    assign if4.in_line  = (sel_r == 1) && line_r;
    assign if4.lane_dat = {dat_r[3], dat_r[2], dat_r[1], dat_r[0]};
    assign if4.lane_vld = (sel_r == 1) ? vld_r : 4'b0000;

    csi_lane_aligner #(.NUM_LANE(2), .DEPTH(DEPTH)) u_dut2 (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (if2.slave)
    );

    csi_lane_aligner #(.NUM_LANE(4), .DEPTH(DEPTH)) u_dut4 (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (if4.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expectation queue whenever a DUT presents a word or an error pulse.
    task automatic mon(input int sel, input logic vld, input logic [31:0] dat, input logic err);
        exp_t e;
        int   ee;
        if (vld) begin
            if ((sel == 0 && q2.size() == 0) || (sel == 1 && q4.size() == 0)) begin
                n_vec++;
                n_miss++;
                $display("FAIL lane%0d_word: unexpected out_dat %0h at edge %0d, none expected",
                         sel ? 4 : 2, dat, cyc);
            end else begin
                if (sel == 0) e = q2.pop_front();
                else          e = q4.pop_front();
                check($sformatf("lane%0d_word_data", sel ? 4 : 2), 64'(dat), 64'(e.data));
                check($sformatf("lane%0d_word_edge", sel ? 4 : 2), 64'(cyc), 64'(e.edge_n));
            end
        end
        if (err) begin
            if ((sel == 0 && eq2.size() == 0) || (sel == 1 && eq4.size() == 0)) begin
                n_vec++;
                n_miss++;
                $display("FAIL lane%0d_err: unexpected err_skew at edge %0d, none expected",
                         sel ? 4 : 2, cyc);
            end else begin
                if (sel == 0) ee = eq2.pop_front();
                else          ee = eq4.pop_front();
                check($sformatf("lane%0d_err_edge", sel ? 4 : 2), 64'(cyc), 64'(ee));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, if2.out_vld, 32'(if2.out_dat), if2.err_skew);
        mon(1, if4.out_vld, if4.out_dat, if4.err_skew);
    end

    // One packet: offsets/lengths are relative to the first sampling edge s; the hand-computed
    // expectations are nw words starting at edge s+first and an optional error at s+err_rel.
    task automatic run_pkt(input int sel, input int off[4], input int nb[4],
                           input logic [7:0] base[4], input int line_len,
                           input int nw, input int first, input int err_rel);
        int   nl;
        int   s;
        exp_t e;
        nl = sel ? 4 : 2;
        @(negedge clk);
        sel_r = sel;
        s = cyc + 1;
        for (int n = 0; n < nw; n++) begin
            e.edge_n = s + first + n;
            e.data   = '0;
            for (int k = 0; k < nl; k++) e.data[8*k +: 8] = base[k] + 8'(n);
            if (sel == 0) q2.push_back(e);
            else          q4.push_back(e);
        end
        if (err_rel >= 0) begin
            if (sel == 0) eq2.push_back(s + err_rel);
            else          eq4.push_back(s + err_rel);
        end
        for (int i = 0; i < line_len; i++) begin
            line_r = 1'b1;
            for (int k = 0; k < 4; k++) begin
                vld_r[k] = (k < nl) && (i >= off[k]) && (i < off[k] + nb[k]);
                dat_r[k] = vld_r[k] ? base[k] + 8'(i - off[k]) : 8'h00;
            end
            if (i == line_len - 1)
                check("aligned_in_packet", 64'(sel ? if4.aligned : if2.aligned), 64'(err_rel < 0));
            @(negedge clk);
        end
        line_r = 1'b0;
        vld_r  = '0;
        for (int k = 0; k < 4; k++) dat_r[k] = 8'h00;
        @(negedge clk);
        #1;
        check("aligned_after_drop", 64'(sel ? if4.aligned : if2.aligned), 64'(0));
        check("words_outstanding", 64'(sel ? q4.size() : q2.size()), 64'(0));
        check("errs_outstanding", 64'(sel ? eq4.size() : eq2.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    // Packet interrupted by a short asynchronous reset while ALIGNED.
    task automatic reset_mid();
        int   s;
        exp_t e;
        @(negedge clk);
        sel_r = 0;
        s = cyc + 1;
        for (int n = 0; n < 4; n++) begin
            e.edge_n = s + 1 + n;
            e.data   = {16'h0, 8'hC0 + 8'(n), 8'h40 + 8'(n)};
            q2.push_back(e);
        end
        for (int i = 0; i < 5; i++) begin
            line_r   = 1'b1;
            vld_r    = 4'b0011;
            dat_r[0] = 8'h40 + 8'(i);
            dat_r[1] = 8'hC0 + 8'(i);
            @(negedge clk);
        end
        check("aligned_before_reset", 64'(if2.aligned), 64'(1));
        #2 areset_n = 1'b0;
        #1;
        check("rst_mid_out_vld", 64'(if2.out_vld), 64'(0));
        check("rst_mid_out_dat", 64'(if2.out_dat), 64'(0));
        check("rst_mid_aligned", 64'(if2.aligned), 64'(0));
        check("rst_mid_err", 64'(if2.err_skew), 64'(0));
        line_r = 1'b0;
        vld_r  = '0;
        @(negedge clk);
        areset_n = 1'b1;
        check("rst_mid_words_outstanding", 64'(q2.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        areset_n = 1'b0;
        line_r   = 1'b0;
        vld_r    = '0;
        sel_r    = 0;
        for (int k = 0; k < 4; k++) dat_r[k] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_out_vld2", 64'(if2.out_vld), 64'(0));
        check("rst_out_dat2", 64'(if2.out_dat), 64'(0));
        check("rst_err2", 64'(if2.err_skew), 64'(0));
        check("rst_aligned2", 64'(if2.aligned), 64'(0));
        check("rst_out_vld4", 64'(if4.out_vld), 64'(0));
        check("rst_out_dat4", 64'(if4.out_dat), 64'(0));
        check("rst_err4", 64'(if4.err_skew), 64'(0));
        check("rst_aligned4", 64'(if4.aligned), 64'(0));
        areset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Zero skew: first word one edge after both lanes start (0x2211 first).
        run_pkt(0, '{0, 0, 0, 0}, '{16, 16, 0, 0}, '{8'h11, 8'h22, 8'h00, 8'h00}, 18, 16, 1, -1);
        // Skew 3 = DEPTH-1: tolerated, 64 paired words.
        run_pkt(0, '{0, 3, 0, 0}, '{64, 64, 0, 0}, '{8'h30, 8'hA0, 8'h00, 8'h00}, 68, 64, 4, -1);
        // Skew 4: timeout error DEPTH-1 edges after the first lane, no words.
        run_pkt(0, '{0, 4, 0, 0}, '{8, 8, 0, 0}, '{8'h50, 8'h60, 8'h00, 8'h00}, 10, 0, -1, 3);
        // in_line drops after 5 words with 2 lane-0 bytes still buffered.
        run_pkt(0, '{0, 2, 0, 0}, '{7, 5, 0, 0}, '{8'h70, 8'hE0, 8'h00, 8'h00}, 8, 5, 3, -1);
        // Next packet must not see the discarded bytes.
        run_pkt(0, '{0, 0, 0, 0}, '{4, 4, 0, 0}, '{8'h01, 8'h81, 8'h00, 8'h00}, 6, 4, 1, -1);
        // Lane 1 stalls: lane 0 fills its FIFO and overflows on the 8th edge.
        run_pkt(0, '{0, 0, 0, 0}, '{10, 3, 0, 0}, '{8'h90, 8'h10, 8'h00, 8'h00}, 12, 3, 1, 7);

        reset_mid();
        // First packet after reset: lane 0 one cycle late.
        run_pkt(0, '{1, 0, 0, 0}, '{6, 6, 0, 0}, '{8'hB0, 8'h20, 8'h00, 8'h00}, 9, 6, 2, -1);

        // Four lanes with staggered starts 0/2/1/3.
        run_pkt(1, '{0, 2, 1, 3}, '{12, 12, 12, 12}, '{8'h10, 8'h20, 8'h30, 8'h40}, 17, 12, 4, -1);
        // Four lanes, lane 2 four cycles behind lane 0: error.
        run_pkt(1, '{0, 1, 4, 2}, '{8, 8, 8, 8}, '{8'h00, 8'h00, 8'h00, 8'h00}, 8, 0, -1, 3);
        // Four lanes recover with zero skew.
        run_pkt(1, '{0, 0, 0, 0}, '{5, 5, 5, 5}, '{8'hA1, 8'hB2, 8'hC3, 8'hD4}, 7, 5, 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/csi_lane_aligner.md
Name: csi_lane_aligner

Overview:
Parametrised multi-lane byte de-skew stage. It sits between the per-lane D-PHY byte receivers/sync detectors and the CSI word assembler inside csi_rx_top, in the csi_byte_clk domain. It replaces the fixed 2-lane alignment with a NUM_LANE-generic aligner (1/2/4 lanes). It adds bounded skew absorption, skew-overflow error reporting and per-packet flush on in_line deassertion.

Parameters:
NUM_LANE, 2, number of D-PHY data lanes; legal values 1, 2, 4.
DEPTH, 4, per-lane FIFO depth in bytes; max tolerated inter-lane skew is DEPTH-1 cycles; power of 2, 2..16.

Ports:
clk  input  1  byte clock (csi_byte_clk)
areset_n  input  1  asynchronous active-low reset
in_line  input  1  high for the duration of a packet; falling edge ends the packet
lane_dat  input  8*NUM_LANE  per-lane byte, lane k at bits [8k+7:8k]
lane_vld  input  NUM_LANE  per-lane byte valid; first assertion marks the byte after SoT sync
out_dat  output  8*NUM_LANE  aligned bytes, lane order preserved
out_vld  output  1  aligned word valid
err_skew  output  1  one-cycle pulse on skew or FIFO overflow
aligned  output  1  high while in ALIGNED state

Behaviour:
- Reset (areset_n low, async): state IDLE; FIFOs empty; seen flags 0; skew counter 0; out_dat 0, out_vld 0, err_skew 0, aligned 0.
- Per lane: a DEPTH-entry FIFO. It is written on every clk edge where lane_vld[k]=1 and state is not ERROR. Simultaneous push and pop on a full FIFO is legal and is not an overflow.
- seen[k] is a sticky flag set on the first lane_vld[k] of a packet. all_seen = AND over k of (seen[k] | lane_vld[k]).
- State IDLE: if in_line=1 and any lane_vld=1, set skew counter to 0. If all_seen is also true, go to ALIGNED; otherwise go to WAIT_ALL.
- State WAIT_ALL: skew counter increments each cycle.
  - If all_seen, go to ALIGNED.
  - Else if counter==DEPTH-1 (i.e. the next byte would be skew DEPTH), go to ERROR and pulse err_skew.
  - all_seen takes priority over timeout in the same cycle.
- State ALIGNED: aligned=1.
  - When every FIFO is non-empty, pop all FIFOs together.
  - out_dat is registered with the popped bytes; out_vld=1 in the following cycle. Otherwise out_vld=0 and out_dat holds its value.
  - A push to a full FIFO without a pop goes to ERROR and pulses err_skew.
- State ERROR: flush all FIFOs; ignore lane_vld; out_vld=0; stay in ERROR until in_line=0.
- In any state, in_line=0 (sampled) does the following on the same edge: go to IDLE, flush FIFOs, clear seen flags and counter, and force out_vld=0 next cycle. Partial words left in the FIFOs are discarded. in_line=0 takes priority over every other transition.
- Latency: the last lane's first valid byte is written at edge t, the state goes to ALIGNED at edge t, and out_vld first rises in cycle t+2. Steady state is one word per cycle with no bubbles when lanes are continuous.
- NUM_LANE=1: WAIT_ALL is never entered; the same 2-cycle latency applies.
- err_skew is exactly 1 cycle wide; at most one pulse per packet.
- Reset mid-packet: async clear to reset values; the next packet is aligned normally.

Decomposition:
- Shared package csi_pkg:
  - typedef enum for states {IDLE, WAIT_ALL, ALIGNED, ERROR};
  - localparam BYTE_W=8;
  - NUM_LANE default (shared with top-level NUM_LANE).
- Sub-module csi_lane_fifo: single-lane synchronous FIFO parametrised by DEPTH, with push, pop, flush, full, empty and async active-low reset. It is instantiated NUM_LANE times via generate.

Test Plan:
- NUM_LANE=2, DEPTH=4; both lanes first valid at cycle 10 with bytes 0x11/0x22, incrementing → out_vld first high at cycle 12 with out_dat=0x2211; continuous words thereafter; err_skew never asserted.
- NUM_LANE=2, DEPTH=4; lane0 first at cycle 10, lane1 at cycle 13 (skew 3) → no error; out_vld first at cycle 15; lane0 byte n is paired with lane1 byte n for 64 words.
- NUM_LANE=2, DEPTH=4; lane0 at cycle 10, lane1 at cycle 14 (skew 4) → err_skew pulse at cycle 14 (1 cycle); out_vld stays 0; after in_line falls, the next packet with zero skew aligns normally.
- NUM_LANE=4; lane first-valid cycles 20/22/21/23 → out_vld first at cycle 25; each output word holds the four lanes' n-th bytes in lane order.
- in_line drops after 5 output words with 2 bytes pending → out_vld low the next cycle; pending bytes never output; aligned=0; IDLE is reached.
- areset_n pulsed low mid-ALIGNED for 1 cycle → all outputs 0 immediately (async); the following packet produces its first out_vld 2 cycles after the last lane's first valid.
